alu_seq_muldiv: RTL and testbench
=================================

// Module: alu_seq_muldiv
// PURPOSE
//  Parametrised next-generation execute unit for the RISC_V core: all RV32I ALU ops plus
//  RV32M multiply/divide on XLEN-bit operands. Registered result behind a valid/ready
//  handshake. Base ops take 1 cycle; MUL*/DIV*/REM* are iterative and take XLEN+1 cycles.
//  Sits between decode/issue and writeback; the issue stage stalls while in_ready=0.
// PARAMETERS
//  XLEN     32             operand/result width; power of 2, >= 8
//  SHAMT_W  $clog2(XLEN)   localparam; shift amount = src_b[SHAMT_W-1:0]
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     reset, asynchronous, active-low
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept request
//  alu_op     in   5     operation code (table below)
//  src_a      in   XLEN  operand A
//  src_b      in   XLEN  operand B
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  registered result
//  busy       out  1     1 whenever state != IDLE
// BEHAVIOUR
//  Op codes: 00000 ADD, 00001 SUB, 00010 SLL, 00011 SLT, 00100 SLTU, 00101 XOR, 00110 SRL,
//   00111 SRA, 01000 OR, 01001 AND, 01010 LUI (result=src_b); 10000 MUL, 10001 MULH,
//   10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
//   Any other code: result 0, latency 1.
//  Reset (rst_n low, async): state IDLE, out_valid 0, result 0, busy 0, counter 0;
//   in_ready forced 0 while rst_n low. An in-flight op is discarded; no output for it.
//  FSM IDLE -> {DONE | CALC}; CALC -> DONE; DONE -> IDLE.
//   IDLE: in_ready=1. Accept on in_valid&&in_ready; latch alu_op, src_a, src_b.
//    Later input changes are ignored until the next accept.
//   Base op, undefined op, or div special case: compute, load result, go to DONE.
//    out_valid=1 on the cycle after the accept edge.
//   MUL*/DIV*/REM* otherwise: go to CALC and load counter=XLEN.
//    Multiply: radix-2 shift-add on magnitudes, 2*XLEN-bit product, sign fix at end.
//    Divide: restoring, one quotient bit per cycle, sign fix at end.
//   CALC: one step per cycle; counter decrements. At counter==1 load result, go to DONE.
//    out_valid rises XLEN+1 cycles after the accept edge.
//   DONE: out_valid=1; result held stable. When out_ready=1, go to IDLE.
//    in_ready returns 1 the next cycle; no same-cycle re-accept.
//  Arithmetic: ADD/SUB wrap mod 2^XLEN. SRA is arithmetic. SLT is signed, SLTU unsigned.
//   MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits
//   (ss / su / uu signedness).
//   DIV/REM truncate toward zero; the remainder takes the sign of the dividend.
//  Divide special cases (latency 1, CALC skipped):
//   divisor 0: DIV/DIVU -> all ones; REM/REMU -> src_a.
//   signed overflow (src_a = 1 followed by XLEN-1 zeros, src_b = -1):
//    DIV -> src_a; REM -> 0.
//  Backpressure: out_ready may stay low indefinitely; result and out_valid hold.
// TESTING
//  ADD 5,7 accepted at edge 0 -> out_valid at edge 1, result 12; out_ready=1 -> in_ready=1 at edge 2.
//  MUL 0xFFFFFFFF,2 -> 0xFFFFFFFE; MULHU same operands -> 0x00000001; MULH same -> 0xFFFFFFFF;
//   each with out_valid exactly 33 cycles after accept.
//  DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100,7 -> 14; REMU 100,7 -> 2.
//  DIVU 10,0 -> 0xFFFFFFFF and REMU 10,0 -> 10 (latency 1); DIV 0x80000000,0xFFFFFFFF -> 0x80000000,
//   REM with the same operands -> 0.
//  Hold out_ready=0 for 5 cycles after SLL 1,35 -> result 8 stable, in_ready=0, busy=1 throughout;
//   src_a toggled meanwhile has no effect.
//  Drop rst_n 10 cycles into a MUL -> out_valid and result 0 immediately; after release,
//   ADD 1,1 -> 2 with latency 1.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// Execute unit for RV32I ALU ops and RV32M multiply/divide behind a valid/ready handshake.
// Base ops finish in one cycle; MUL*/DIV*/REM* iterate one bit per cycle over XLEN steps.
module alu_seq_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = $clog2(XLEN + 1);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_SLL  = 5'b00010;
    localparam logic [4:0] OP_SLT  = 5'b00011;
    localparam logic [4:0] OP_SLTU = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_LUI  = 5'b01010;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);

    // Request decode: operand signedness, magnitudes and single-cycle divide cases
    logic              in_md, in_div, in_a_signed, in_b_signed, in_a_neg, in_b_neg;
    logic              div_zero, div_ovf, div_special;
    logic [XLEN-1:0]   mag_a, mag_b, quick_res;
    logic [SHAMT_W-1:0] shamt;

    always_comb begin
        in_md       = (alu_op[4:3] == 2'b10);
        in_div      = in_md && alu_op[2];
        in_a_signed = in_div ? !alu_op[0] : (alu_op[1:0] != 2'b11);
        in_b_signed = in_div ? !alu_op[0] : !alu_op[1];
        in_a_neg    = in_a_signed && src_a[XLEN-1];
        in_b_neg    = in_b_signed && src_b[XLEN-1];
        mag_a       = in_a_neg ? -src_a : src_a;
        mag_b       = in_b_neg ? -src_b : src_b;
        div_zero    = in_div && (src_b == '0);
        div_ovf     = in_div && !alu_op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        div_special = div_zero || div_ovf;
        shamt       = src_b[SHAMT_W-1:0];

        quick_res = '0;
        case (alu_op)
            OP_ADD:  quick_res = src_a + src_b;
            OP_SUB:  quick_res = src_a - src_b;
            OP_SLL:  quick_res = src_a << shamt;
            OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  quick_res = src_a ^ src_b;
            OP_SRL:  quick_res = src_a >> shamt;
            OP_SRA:  quick_res = $signed(src_a) >>> shamt;
            OP_OR:   quick_res = src_a | src_b;
            OP_AND:  quick_res = src_a & src_b;
            OP_LUI:  quick_res = src_b;
            default: quick_res = '0;
        endcase
        if (div_zero) begin
            quick_res = alu_op[1] ? src_a : '1;
        end else if (div_ovf) begin
            quick_res = alu_op[1] ? '0 : src_a;
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN:0]     step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q[XLEN-1:0]} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_hi_q[XLEN-1:0], acc_lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff;
                step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_sh;
                step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = {1'b0, mul_sum[XLEN:1]};
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end

        prod     = {step_hi[XLEN-1:0], step_lo};
        prod_fix = qneg_q ? -prod : prod;
        quot_fix = qneg_q ? -step_lo : step_lo;
        rem_fix  = rneg_q ? -step_hi[XLEN-1:0] : step_hi[XLEN-1:0];

        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fix : quot_fix;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d = alu_op;
                    if (in_md && !div_special) begin
                        state_d  = S_CALC;
                        cnt_d    = CNT_W'(XLEN);
                        acc_hi_d = '0;
                        acc_lo_d = in_div ? mag_a : mag_b;
                        opnd_d   = in_div ? mag_b : mag_a;
                        qneg_d   = in_a_neg ^ in_b_neg;
                        rneg_d   = in_a_neg;
                    end else begin
                        state_d     = S_DONE;
                        result_d    = quick_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                cnt_d    = cnt_q - 1'b1;
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_DONE;
                    result_d    = final_res;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv: expected results queued at issue, compared on out_valid.
module tb_alu_seq_muldiv;
    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, SLL = 5'b00010, SLT = 5'b00011;
    localparam logic [4:0] SLTU = 5'b00100, XOR_ = 5'b00101, SRL = 5'b00110, SRA = 5'b00111;
    localparam logic [4:0] OR_ = 5'b01000, AND_ = 5'b01001, LUI = 5'b01010, UNDEF = 5'b01011;
    localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011;
    localparam logic [4:0] DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];

    alu_seq_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency and result, optionally stall the consumer, then drain.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int hold);
        int          cyc;
        logic        seen;
        logic [31:0] exp_r;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        alu_op   = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        sb.push_back(exp);
        cyc  = 0;
        seen = 1'b0;
        exp_r = '0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            in_valid = 1'b0;
            src_a    = $urandom;
            src_b    = $urandom;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, cyc, lat);
        if (seen) begin
            exp_r = sb.pop_front();
            check(tag, result, exp_r);
            $display("[TB] %s op=%b a=%h b=%h result=%h latency=%0d", tag, op, a, b, result, cyc);
        end else begin
            void'(sb.pop_front());
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            src_a = ~src_a;
            check({tag, "_hold_result"}, result, exp_r);
            check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
            check({tag, "_hold_busy"}, {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_drain_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add", ADD, 32'd5, 32'd7, 32'd12, 1, 0);
        run_op("sub", SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 0);
        run_op("slt", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
        run_op("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        run_op("xor", XOR_, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1, 0);
        run_op("srl", SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, 0);
        run_op("sra", SRA, 32'h8000_0000, 32'd36, 32'hF800_0000, 1, 0);
        run_op("or", OR_, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1, 0);
        run_op("and", AND_, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 0);
        run_op("lui", LUI, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1, 0);
        run_op("undef", UNDEF, 32'd9, 32'd9, 32'd0, 1, 0);
        run_op("sll_bp", SLL, 32'd1, 32'd35, 32'd8, 1, 5);

        run_op("mul", MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 0);
        run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33, 0);
        run_op("mulh", MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
        ra = 32'hDEAD_BEEF;
        rb = 32'h1234_5678;
        p  = {32'b0, ra} * {32'b0, rb};
        run_op("mulhu_rnd", MULHU, ra, rb, p[63:32], 33, 0);
        run_op("mul_rnd", MUL, ra, rb, p[31:0], 33, 0);

        run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu", REMU, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("divu_z", DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_z", REMU, 32'd10, 32'd0, 32'd10, 1, 0);
        run_op("div_z", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Reset during an in-flight multiply discards it
        @(negedge clk);
        alu_op   = MUL;
        src_a    = 32'd3;
        src_b    = 32'd4;
        in_valid = 1'b1;
        sb.push_back(32'd12);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_in_ready", {31'b0, in_ready}, 32'd0);
        $display("[TB] reset mid-MUL out_valid=%b result=%h", out_valid, result);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_after_rst", ADD, 32'd1, 32'd1, 32'd2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
